mux_uart: RTL

//   Multi-channel bus-attached serial UART replacing the simulation-only "print on write" stub.

---
 rtl/mux_uart_pkg.sv | 18 +
 rtl/mux_uart_if.sv | 12 +
 rtl/mux_uart_channel.sv | 248 ++++++++++++++++++++++++
 rtl/mux_uart.sv | 65 ++++++
 4 files changed

// File: rtl/mux_uart_pkg.sv
// Shared constants and FSM state types for the bus-attached multi-channel UART.
package mux_uart_pkg;

    // Status register bit positions
    localparam int unsigned ST_RX_RDY  = 0;
    localparam int unsigned ST_TX_NF   = 1;
    localparam int unsigned ST_TX_IDLE = 2;
    localparam int unsigned ST_OVR     = 3;
    localparam int unsigned ST_FRM     = 4;

    // Register offset within a channel's two-byte slot
    localparam logic OFS_STATUS = 1'b0;
    localparam logic OFS_DATA   = 1'b1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

endpackage

// File: rtl/mux_uart_if.sv
// CPU6 bus register-window signals shared between the CPU side and the UART.
interface mux_uart_if;
    logic [18:0] address;
    logic        write_en;
    logic        read_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        select;

    modport master (output address, write_en, read_en, data_in, input data_out, select);
    modport slave  (input address, write_en, read_en, data_in, output data_out, select);
endinterface

// File: rtl/mux_uart_channel.sv
// One serial channel: TX FIFO, 8N1 serializer, synchronized RX deserializer and status.
module mux_uart_channel
    import mux_uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wr_data_i,
    input  logic       rd_data_i,
    input  logic [7:0] wdata_i,
    input  logic       rx_i,
    output logic       tx_o,
    output logic [7:0] status_o,
    output logic [7:0] rx_data_o,
    output logic       rx_rdy_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned TW = $clog2(CLK_DIV);
    localparam logic [TW-1:0] BitReload  = TW'(CLK_DIV - 1);
    localparam logic [TW-1:0] HalfReload = TW'(CLK_DIV / 2 - 1);
    localparam logic [TW-1:0] TimerOne   = TW'(1);
    localparam logic [AW:0]   PtrOne     = {{AW{1'b0}}, 1'b1};

    // TX FIFO
    logic [7:0]  mem_q [FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full, push, pop;
    logic [7:0]  fifo_head;

    // TX serializer
    tx_state_e   tx_state_q, tx_state_d;
    logic [TW-1:0] tx_timer_q, tx_timer_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [2:0]  tx_bit_q, tx_bit_d;
    logic        tx_q, tx_d, tx_tick;

    // RX deserializer and holding register
    logic        rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;
    rx_state_e   rx_state_q, rx_state_d;
    logic [TW-1:0] rx_timer_q, rx_timer_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [2:0]  rx_bit_q, rx_bit_d;
    logic        rx_tick, rx_load;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rdy_q, rdy_d, ovr_q, ovr_d, frm_q, frm_d;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push       = wr_data_i && !fifo_full;
    assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
    assign tx_tick    = (tx_timer_q == '0);
    assign rx_tick    = (rx_timer_q == '0);
    assign rx_fall    = rx_s3_q && !rx_s2_q;

    // FIFO pointer advance; a full FIFO drops the write
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
    end

    // FIFO storage needs no reset; pointers define validity
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

    // TX state register and datapath flops; tx idles high from reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tx_state_q <= TX_IDLE;
            tx_timer_q <= '0;
            tx_shift_q <= '0;
            tx_bit_q   <= '0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_timer_q <= tx_timer_d;
            tx_shift_q <= tx_shift_d;
            tx_bit_q   <= tx_bit_d;
            tx_q       <= tx_d;
        end
    end

    // TX next state; stop bit chains straight into the next start when data is queued
    always_comb begin
        tx_state_d = tx_state_q;
        unique case (tx_state_q)
            TX_IDLE:  if (!fifo_empty) tx_state_d = TX_START;
            TX_START: if (tx_tick) tx_state_d = TX_DATA;
            TX_DATA:  if (tx_tick && tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            TX_STOP:  if (tx_tick) tx_state_d = fifo_empty ? TX_IDLE : TX_START;
            default:  tx_state_d = TX_IDLE;
        endcase
    end

    // TX outputs: line level, bit timer, shifter and FIFO pop
    always_comb begin
        tx_timer_d = tx_tick ? BitReload : tx_timer_q - TimerOne;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        unique case (tx_state_q)
            TX_IDLE: begin
                tx_timer_d = BitReload;
                tx_d       = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_head;
                    tx_d       = 1'b0;
                end
            end
            TX_START: begin
                if (tx_tick) begin
                    tx_d       = tx_shift_q[0];
                    tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    tx_bit_d   = 3'd0;
                end
            end
            TX_DATA: begin
                if (tx_tick) begin
                    if (tx_bit_q == 3'd7) begin
                        tx_d = 1'b1;
                    end else begin
                        tx_d       = tx_shift_q[0];
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                        tx_bit_d   = tx_bit_q + 3'd1;
                    end
                end
            end
            TX_STOP: begin
                if (tx_tick) begin
                    tx_d = 1'b1;
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        tx_shift_d = fifo_head;
                        tx_d       = 1'b0;
                    end
                end
            end
            default: tx_d = 1'b1;
        endcase
    end

    // RX state register, synchronizer, holding register and FIFO pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_s1_q    <= 1'b1;
            rx_s2_q    <= 1'b1;
            rx_s3_q    <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_timer_q <= '0;
            rx_shift_q <= '0;
            rx_bit_q   <= '0;
            rx_data_q  <= '0;
            rdy_q      <= 1'b0;
            ovr_q      <= 1'b0;
            frm_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            rx_s1_q    <= rx_i;
            rx_s2_q    <= rx_s1_q;
            rx_s3_q    <= rx_s2_q;
            rx_state_q <= rx_state_d;
            rx_timer_q <= rx_timer_d;
            rx_shift_q <= rx_shift_d;
            rx_bit_q   <= rx_bit_d;
            rx_data_q  <= rx_data_d;
            rdy_q      <= rdy_d;
            ovr_q      <= ovr_d;
            frm_q      <= frm_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // RX next state; START re-checks the line at half a bit to reject glitches
    always_comb begin
        rx_state_d = rx_state_q;
        unique case (rx_state_q)
            RX_IDLE:  if (rx_fall) rx_state_d = RX_START;
            RX_START: if (rx_tick) rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP:  if (rx_tick) rx_state_d = RX_IDLE;
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs: bit timer, shifter and byte-load strobe
    always_comb begin
        rx_timer_d = rx_tick ? BitReload : rx_timer_q - TimerOne;
        rx_shift_d = rx_shift_q;
        rx_bit_d   = rx_bit_q;
        rx_load    = 1'b0;
        unique case (rx_state_q)
            RX_IDLE:  rx_timer_d = HalfReload;
            RX_START: if (rx_tick) rx_bit_d = 3'd0;
            RX_DATA: begin
                if (rx_tick) begin
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                end
            end
            RX_STOP:  rx_load = rx_tick;
            default:  rx_timer_d = HalfReload;
        endcase
    end

    // Holding register: a byte load beats a clearing read in the same cycle
    always_comb begin
        rx_data_d = rx_data_q;
        rdy_d     = rdy_q;
        ovr_d     = ovr_q;
        frm_d     = frm_q;
        if (rx_load) begin
            rx_data_d = rx_shift_q;
            rdy_d     = 1'b1;
            if (rd_data_i) begin
                ovr_d = 1'b0;
                frm_d = !rx_s2_q;
            end else begin
                ovr_d = ovr_q | rdy_q;
                frm_d = frm_q | !rx_s2_q;
            end
        end else if (rd_data_i) begin
            rdy_d = 1'b0;
            ovr_d = 1'b0;
            frm_d = 1'b0;
        end
    end

    // Status byte assembly
    always_comb begin
        status_o             = '0;
        status_o[ST_RX_RDY]  = rdy_q;
        status_o[ST_TX_NF]   = !fifo_full;
        status_o[ST_TX_IDLE] = fifo_empty && (tx_state_q == TX_IDLE);
        status_o[ST_OVR]     = ovr_q;
        status_o[ST_FRM]     = frm_q;
    end

    assign tx_o      = tx_q;
    assign rx_data_o = rx_data_q;
    assign rx_rdy_o  = rdy_q;

endmodule

// File: rtl/mux_uart.sv
// Multi-channel UART on the CPU6 bus: window decode, read mux, channel array and irq.
module mux_uart
    import mux_uart_pkg::*;
#(
    parameter int unsigned CHANNELS   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_DIV    = 16,
    parameter logic [18:0] BASE_ADDR  = 19'h3f200
) (
    input  logic                clock,
    input  logic                reset,
    mux_uart_if.slave           bus,
    output logic [CHANNELS-1:0] tx,
    input  logic [CHANNELS-1:0] rx,
    output logic                irq
);
    logic [18:0]         offset;
    logic                hit;
    logic [17:0]         ch_sel;
    logic                reg_sel;
    logic [7:0]          status [CHANNELS];
    logic [7:0]          rx_data [CHANNELS];
    logic [CHANNELS-1:0] rx_rdy;

    // Addresses below the base wrap to large offsets and miss
    assign offset     = bus.address - BASE_ADDR;
    assign hit        = offset < 19'(2 * CHANNELS);
    assign ch_sel     = offset[18:1];
    assign reg_sel    = offset[0];
    assign bus.select = hit;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic ch_hit;
        assign ch_hit = hit && (ch_sel == 18'(g)) && (reg_sel == OFS_DATA);

        mux_uart_channel #(
            .FIFO_DEPTH (FIFO_DEPTH),
            .CLK_DIV    (CLK_DIV)
        ) u_channel (
            .clk_i     (clock),
            .rst_i     (reset),
            .wr_data_i (ch_hit && bus.write_en),
            .rd_data_i (ch_hit && bus.read_en),
            .wdata_i   (bus.data_in),
            .rx_i      (rx[g]),
            .tx_o      (tx[g]),
            .status_o  (status[g]),
            .rx_data_o (rx_data[g]),
            .rx_rdy_o  (rx_rdy[g])
        );
    end

    // Read mux, combinational from the address
    always_comb begin
        bus.data_out = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (hit && ch_sel == 18'(i)) begin
                bus.data_out = (reg_sel == OFS_DATA) ? rx_data[i] : status[i];
            end
        end
    end

    assign irq = |rx_rdy;

endmodule
